// File: rtl/aes_decrypt_core.sv
// AES-128 inverse cipher, one round per clock.
// Round keys are expanded on chip before each block is decrypted.
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_EXP,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t       r_fsm;
  logic [3:0]   r_rcnt;
  logic [127:0] r_ct;
  logic [127:0] r_state;
  logic [127:0] r_rk [0:10];
  logic [127:0] r_pt;
  logic         r_done;
  logic         r_busy;

  function automatic logic [7:0] f_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = f_xt(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0.
  function automatic logic [7:0] f_ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = f_gmul(r, r);
      if (i != 0) r = f_gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = f_ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] f_isbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]} ^ 8'h05;
    return f_ginv(b);
  endfunction

  // Row r rotates right by r; byte n sits at row n%4, column n/4.
  function automatic logic [127:0] f_inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] f_inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = f_isbox(s[127-8*n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] f_inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = f_gmul(a0, 8'h0e) ^ f_gmul(a1, 8'h0b)
                       ^ f_gmul(a2, 8'h0d) ^ f_gmul(a3, 8'h09);
      o[119-32*c -: 8] = f_gmul(a0, 8'h09) ^ f_gmul(a1, 8'h0e)
                       ^ f_gmul(a2, 8'h0b) ^ f_gmul(a3, 8'h0d);
      o[111-32*c -: 8] = f_gmul(a0, 8'h0d) ^ f_gmul(a1, 8'h09)
                       ^ f_gmul(a2, 8'h0e) ^ f_gmul(a3, 8'h0b);
      o[103-32*c -: 8] = f_gmul(a0, 8'h0b) ^ f_gmul(a1, 8'h0d)
                       ^ f_gmul(a2, 8'h09) ^ f_gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [3:0]   w_rcnt_m1;
  logic [127:0] w_prev_rk;
  logic [31:0]  w_rot;
  logic [31:0]  w_tmp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next_rk;
  logic [127:0] w_isb;
  logic [127:0] w_round;
  logic [127:0] w_final;

  // Next round key is derived from the previously stored one.
  assign w_rcnt_m1 = r_rcnt - 4'd1;
  assign w_prev_rk = r_rk[w_rcnt_m1];
  assign w_rot     = {w_prev_rk[23:0], w_prev_rk[31:24]};
  assign w_tmp     = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]),
                      f_sbox(w_rot[15:8]),  f_sbox(w_rot[7:0])}
                   ^ {f_rcon(r_rcnt), 24'h0};
  assign w_n0      = w_prev_rk[127:96] ^ w_tmp;
  assign w_n1      = w_prev_rk[95:64]  ^ w_n0;
  assign w_n2      = w_prev_rk[63:32]  ^ w_n1;
  assign w_n3      = w_prev_rk[31:0]   ^ w_n2;
  assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

  // Shared round datapath; the last round skips InvMixColumns.
  assign w_isb   = f_inv_sub_bytes(f_inv_shift_rows(r_state));
  assign w_round = f_inv_mix_columns(w_isb ^ r_rk[r_rcnt]);
  assign w_final = w_isb ^ r_rk[0];

  // Control FSM with registered datapath state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_rcnt  <= '0;
      r_ct    <= '0;
      r_state <= '0;
      r_pt    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (start) begin
            r_ct    <= ciphertext;
            r_rk[0] <= key;
            r_rcnt  <= 4'd1;
            r_busy  <= 1'b1;
            r_fsm   <= S_KEY_EXP;
          end
        end
        S_KEY_EXP: begin
          r_rk[r_rcnt] <= w_next_rk;
          r_rcnt       <= r_rcnt + 4'd1;
          if (r_rcnt == 4'd10) r_fsm <= S_INIT;
        end
        S_INIT: begin
          r_state <= r_ct ^ r_rk[10];
          r_rcnt  <= 4'd9;
          r_fsm   <= S_ROUND;
        end
        S_ROUND: begin
          r_state <= w_round;
          r_rcnt  <= r_rcnt - 4'd1;
          if (r_rcnt == 4'd1) r_fsm <= S_FINAL;
        end
        S_FINAL: begin
          r_pt   <= w_final;
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_fsm  <= S_DONE;
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_fsm  <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign plaintext = r_pt;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed and loopback checks for aes_decrypt_core.
// Reference encryption uses log/antilog-built S-box tables.
module tb_aes_decrypt_core;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  aes_decrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;

  int           n_checks;
  int           n_err;
  logic [7:0]   sb [256];

  logic [127:0] got_pt;
  int           got_lat;
  logic         busy_e0;
  logic         done_after;
  int           n_ovl;
  int           pulses;
  int           c1, c2;
  logic [127:0] p1, p2;
  logic         b22, b23;
  int           n_done_rst;
  logic [127:0] t_pt, t_key, t_ct;
  string        tag;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  task automatic build_tables();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] p;
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++) begin
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
             ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      end
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] enc(
    input logic [127:0] pt,
    input logic [127:0] k
  );
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int rd = 1; rd <= 10; rd++) begin
      for (int n = 0; n < 16; n++) s[127-8*n -: 8] = sb[s[127-8*n -: 8]];
      o = s;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      s = o;
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        s = o;
      end
      s = s ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
    end
    return s;
  endfunction

  task automatic chk(
    input string        name,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; inputs are scrambled right after acceptance.
  task automatic run(
    input  logic [127:0] ct,
    input  logic [127:0] k,
    output logic [127:0] pt,
    output int           lat
  );
    start      = 1'b1;
    ciphertext = ct;
    key        = k;
    tick();
    start      = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key        = {$urandom, $urandom, $urandom, $urandom};
    busy_e0    = busy;
    lat        = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (busy && done) n_ovl++;
      if (done) begin
        lat = n;
        break;
      end
    end
    pt = plaintext;
    tick();
    done_after = done;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    n_ovl    = 0;
    build_tables();

    rst        = 1'b1;
    start      = 1'b0;
    ciphertext = '0;
    key        = '0;
    #1;
    chk("rst_pt",   plaintext, '0);
    chk("rst_done", 128'(done), '0);
    chk("rst_busy", 128'(busy), '0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    run(C1, K1, got_pt, got_lat);
    chk("v1_pt",        got_pt, P1);
    chk("v1_lat",       128'(got_lat), 128'd21);
    chk("v1_busy_e0",   128'(busy_e0), 128'd1);
    chk("v1_done_once", 128'(done_after), 128'd0);

    run(C2, K2, got_pt, got_lat);
    chk("v2_pt",  got_pt, P2);
    chk("v2_lat", 128'(got_lat), 128'd21);

    start      = 1'b1;
    ciphertext = C1;
    key        = K1;
    tick();
    pulses = 0;
    c1 = -1;
    c2 = -1;
    p1 = '0;
    p2 = '0;
    b22 = 1'bx;
    b23 = 1'bx;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (n == 5) begin
        ciphertext = C2;
        key        = K2;
      end
      if (n == 44) start = 1'b0;
      if (n == 22) b22 = busy;
      if (n == 23) b23 = busy;
      if (busy && done) n_ovl++;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          c1 = n;
          p1 = plaintext;
        end else if (pulses == 2) begin
          c2 = n;
          p2 = plaintext;
        end
      end
    end
    chk("b2b_pulses", 128'(pulses), 128'd2);
    chk("b2b_c1",     128'(c1), 128'd21);
    chk("b2b_p1",     p1, P1);
    chk("b2b_c2",     128'(c2), 128'd44);
    chk("b2b_p2",     p2, P2);
    chk("b2b_b22",    128'(b22), 128'd0);
    chk("b2b_b23",    128'(b23), 128'd1);

    ciphertext = C1;
    key        = K1;
    repeat (5) tick();
    chk("idle_pt",   plaintext, P2);
    chk("idle_done", 128'(done), '0);
    chk("idle_busy", 128'(busy), '0);

    start      = 1'b1;
    ciphertext = C1;
    key        = K1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pt",   plaintext, '0);
    chk("mid_rst_done", 128'(done), '0);
    chk("mid_rst_busy", 128'(busy), '0);
    tick();
    rst = 1'b0;
    n_done_rst = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) n_done_rst++;
    end
    chk("mid_no_done", 128'(n_done_rst), '0);
    chk("mid_pt_hold", plaintext, '0);
    run(C2, K2, got_pt, got_lat);
    chk("after_rst_pt",  got_pt, P2);
    chk("after_rst_lat", 128'(got_lat), 128'd21);

    // Zero key makes the last InvSubBytes see S(p) for every byte value.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) t_pt[127-8*i -: 8] = 8'(16*j + i);
      t_ct = enc(t_pt, '0);
      run(t_ct, '0, got_pt, got_lat);
      tag = $sformatf("sweep%0d_pt", j);
      chk(tag, got_pt, t_pt);
    end

    for (int j = 0; j < 100; j++) begin
      t_pt = {$urandom, $urandom, $urandom, $urandom};
      t_key = {$urandom, $urandom, $urandom, $urandom};
      t_ct = enc(t_pt, t_key);
      run(t_ct, t_key, got_pt, got_lat);
      tag = $sformatf("loop%0d_pt", j);
      chk(tag, got_pt, t_pt);
      tag = $sformatf("loop%0d_lat", j);
      chk(tag, 128'(got_lat), 128'd21);
    end

    chk("busy_done_excl", 128'(n_ovl), '0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; clock and reset are named clk and rst.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 ciphertext  input  128  AES-128 block to decrypt; bits [127:120] are FIPS-197 byte 0, and the state is column-major.
REQ-006 key  input  128  AES-128 cipher key, the same key the encrypting core uses; byte order as ciphertext.
REQ-007 plaintext  output  128  registered result; holds its value until the next completion.
REQ-008 done  output  1  registered; a one-cycle pulse when plaintext is valid.
REQ-009 busy  output  1  high in KEY_EXP, INIT, ROUND and FINAL.

Function
REQ-010 The module SHALL implement the FIPS-197 AES-128 inverse cipher bit-exactly, iterating one round per cycle.
REQ-011 S-box and inverse S-box SHALL be computed as GF(2^8) inverse (polynomial 0x11B) with the affine transform and its inverse, and SHALL match the FIPS-197 tables for all 256 inputs.
REQ-012 FSM states SHALL be IDLE, KEY_EXP, INIT, ROUND, FINAL and DONE.
REQ-013 IDLE with start=1 at edge E0: latch ciphertext and key, store key as rk0, set rcnt=1, and go to KEY_EXP.
REQ-014 IDLE with start=0: stay in IDLE; all outputs hold.
REQ-015 KEY_EXP, edges E1..E10: compute and store rk[rcnt] from rk[rcnt-1] (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1B,36) and increment rcnt; at E10 go to INIT.
REQ-016 INIT, edge E11: state <= latched ciphertext ^ rk10; rcnt=9; go to ROUND.
REQ-017 ROUND, edges E12..E20: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rcnt]); decrement rcnt; when the round using rk1 completes, go to FINAL.
REQ-018 FINAL, edge E21: plaintext <= InvSubBytes(InvShiftRows(state)) ^ rk0; done <= 1; go to DONE.
REQ-019 DONE, edge E22: done <= 0; go to IDLE unconditionally; start in DONE SHALL be ignored.
REQ-020 Latency SHALL be exactly 21 cycles: done is high in the cycle after E21, and the next start is accepted at E23 at the earliest.
REQ-021 start while busy=1 SHALL be ignored, and changes to the ciphertext or key inputs after E0 SHALL NOT affect the result.
REQ-022 busy SHALL be high from after E0 until after E21, and busy and done SHALL never be high together.
REQ-023 Round-key storage SHALL be 11 x 128-bit registers, rk0..rk10, and SHALL NOT be reused across operations without re-expansion.

Reset
REQ-024 rst=1 SHALL immediately force: FSM=IDLE, rcnt=0, state=0, all round keys=0, plaintext=0, done=0, busy=0.
REQ-025 rst asserted mid-operation SHALL abort the operation with no done pulse and no plaintext update.
REQ-026 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-027 key=000102030405060708090a0b0c0d0e0f, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done exactly 21 cycles later with plaintext=00112233445566778899aabbccddeeff.
REQ-028 key=2b7e151628aed2a6abf7158809cf4f3c, ciphertext=3925841d02dc09fbdc118597196a0b32 -> plaintext=3243f6a8885a308d313198a2e0370734.
REQ-029 Back-to-back operation: run the REQ-027 vector, then change the ciphertext and key mid-run and hold start high continuously -> REQ-027 result unchanged, second result correct for the new inputs, second start accepted at E23, one done pulse per operation.
REQ-030 rst pulse at cycle 10 of a run -> done stays 0, plaintext=0, busy=0; a fresh start then yields the correct result.
REQ-031 Exhaustive S-box check over inputs 00..FF against the FIPS-197 tables, e.g. S(00)=63, S(53)=ED, InvS(63)=00, InvS(ED)=53.
REQ-032 Loopback: encrypt 100 random key/plaintext pairs with a reference model, decrypt them through the DUT -> plaintext matches the original every time.
